// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM state definitions for the multi-cycle ALU.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    kADD  = 3'd0,
    kLSH  = 3'd1,
    kRSH  = 3'd2,
    kXOR  = 3'd3,
    kAND  = 3'd4,
    kSUB  = 3'd5,
    kLFSR = 3'd6,
    kNOP  = 3'd7
  } op_mne;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ITER = 1'b1
  } alu_state_t;

  function automatic logic is_iter_op(input op_mne op);
    return (op == kLSH) || (op == kRSH) || (op == kLFSR);
  endfunction

endpackage

// File: rtl/alu_seq_step.sv
// One step of a shift or Fibonacci LFSR advance; purely combinational.
module alu_step
  import alu_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] acc,
  input  logic         fill,
  input  logic [W-1:0] taps,
  input  op_mne        mode,
  output logic [W-1:0] acc_next,
  output logic         sc
);

  always_comb begin
    acc_next = acc;
    sc       = 1'b0;
    case (mode)
      kLSH: begin
        sc       = acc[W-1];
        acc_next = {acc[W-2:0], fill};
      end
      kRSH: begin
        sc       = acc[0];
        acc_next = {fill, acc[W-1:1]};
      end
      kLFSR: begin
        sc       = acc[W-1];
        acc_next = {acc[W-2:0], ^(acc & taps)};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle arith/logic, iterative shifts and LFSR steps.
// Define ALU_BARREL_EN to complete kLSH/kRSH in one cycle with a barrel shifter.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = $clog2(W) + 1
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [2:0]    OP,
  input  logic [W-1:0]  InputA,
  input  logic [W-1:0]  InputB,
  input  logic          SC_in,
  input  logic [CW-1:0] Cnt,
  output logic [W-1:0]  Out,
  output logic          SC_out,
  output logic          Zero,
  output logic          PF,
  output logic          Busy,
  output logic          Done
);

  alu_state_t    state_q, state_d;
  op_mne         mode_q, mode_d;
  logic [W-1:0]  acc_q, acc_d, taps_q, taps_d, out_q, out_d;
  logic [CW-1:0] rem_q, rem_d, cnt_eff;
  logic          fill_q, fill_d, sc_q, sc_d, done_q, done_d, zero_q, pf_q;
  logic [W-1:0]  step_acc;
  logic          step_sc;
  op_mne         op;

  assign op = op_mne'(OP);

  // Shifts past W only refill with the fill bit, so clamp; LFSR runs the full count.
  always_comb begin
    cnt_eff = Cnt;
    if (op != kLFSR && Cnt > CW'(W)) cnt_eff = CW'(W);
  end

  alu_step #(.W(W)) u_step (
    .acc      (acc_q),
    .fill     (fill_q),
    .taps     (taps_q),
    .mode     (mode_q),
    .acc_next (step_acc),
    .sc       (step_sc)
  );

`ifdef ALU_BARREL_EN
  logic [2*W:0] lsh_t, rsh_t;
  logic [W-1:0] bar_acc;
  logic         bar_sc;

  // Guard bits beside the operand catch the last bit shifted out.
  always_comb begin
    lsh_t = {1'b0, InputA, {W{SC_in}}} << cnt_eff;
    rsh_t = {{W{SC_in}}, InputA, 1'b0} >> cnt_eff;
    if (op == kLSH) begin
      bar_acc = lsh_t[2*W-1:W];
      bar_sc  = lsh_t[2*W];
    end else begin
      bar_acc = rsh_t[W:1];
      bar_sc  = rsh_t[0];
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    taps_d  = taps_q;
    fill_d  = fill_q;
    rem_d   = rem_q;
    out_d   = out_q;
    sc_d    = sc_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          done_d = 1'b1;
          case (op)
            kADD: {sc_d, out_d} = {1'b0, InputA} + {1'b0, InputB} + {{W{1'b0}}, SC_in};
            kSUB: {sc_d, out_d} = {1'b0, InputA} + {1'b0, ~InputB} + {{W{1'b0}}, 1'b1};
            kXOR: begin out_d = InputA ^ InputB; sc_d = 1'b0; end
            kAND: begin out_d = InputA & InputB; sc_d = 1'b0; end
            kLSH, kRSH, kLFSR: begin
              if (cnt_eff == '0) begin
                out_d = InputA;
                sc_d  = 1'b0;
              end
`ifdef ALU_BARREL_EN
              else if (op != kLFSR) begin
                out_d = bar_acc;
                sc_d  = bar_sc;
              end
`endif
              else begin
                done_d  = 1'b0;
                acc_d   = InputA;
                taps_d  = InputB;
                fill_d  = SC_in;
                mode_d  = op;
                rem_d   = cnt_eff;
                state_d = S_ITER;
              end
            end
            default: begin out_d = '0; sc_d = 1'b0; end
          endcase
        end
      end
      S_ITER: begin
        acc_d = step_acc;
        rem_d = rem_q - CW'(1);
        if (rem_q == CW'(1)) begin
          out_d   = step_acc;
          sc_d    = step_sc;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      mode_q  <= kNOP;
      acc_q   <= '0;
      taps_q  <= '0;
      fill_q  <= 1'b0;
      rem_q   <= '0;
      out_q   <= '0;
      sc_q    <= 1'b0;
      zero_q  <= 1'b1;
      pf_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      taps_q  <= taps_d;
      fill_q  <= fill_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      sc_q    <= sc_d;
      zero_q  <= (out_d == '0);
      pf_q    <= ^out_d;
      done_q  <= done_d;
    end
  end

  assign Out    = out_q;
  assign SC_out = sc_q;
  assign Zero   = zero_q;
  assign PF     = pf_q;
  assign Busy   = (state_q == S_ITER);
  assign Done   = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed vector bench for alu_seq plus hand sequences for busy/reset/back-to-back.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W  = 8;
  localparam int CW = 4;
`ifdef ALU_BARREL_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic          Clk = 1'b0, Reset_n = 1'b0, Start = 1'b0, SC_in = 1'b0;
  logic [2:0]    OP = 3'd0;
  logic [W-1:0]  InputA = '0, InputB = '0;
  logic [CW-1:0] Cnt = '0;
  logic [W-1:0]  Out;
  logic          SC_out, Zero, PF, Busy, Done;

  int checks = 0, errors = 0;

  alu_seq #(.W(W), .CW(CW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .OP(OP),
    .InputA(InputA), .InputB(InputB), .SC_in(SC_in), .Cnt(Cnt),
    .Out(Out), .SC_out(SC_out), .Zero(Zero), .PF(PF), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    op_mne      op;
    logic [7:0] a, b;
    logic       sc;
    logic [3:0] cnt;
    logic [7:0] eo;
    logic       es;
    int         busy;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int busy_n, guard, dones, exp_busy;
    logic [W-1:0] last_out;

    vt[0]  = '{kADD,  8'hF0, 8'h20, 1'b1, 4'd0,  8'h11, 1'b1, 0};
    vt[1]  = '{kSUB,  8'h05, 8'h05, 1'b0, 4'd0,  8'h00, 1'b1, 0};
    vt[2]  = '{kLSH,  8'hAA, 8'h00, 1'b1, 4'd3,  8'h57, 1'b1, 3};
    vt[3]  = '{kLFSR, 8'h80, 8'hB8, 1'b0, 4'd2,  8'h02, 1'b0, 2};
    vt[4]  = '{kRSH,  8'h3C, 8'h00, 1'b0, 4'd0,  8'h3C, 1'b0, 0};
    vt[5]  = '{kXOR,  8'h5A, 8'hFF, 1'b1, 4'd0,  8'hA5, 1'b0, 0};
    vt[6]  = '{kAND,  8'hF0, 8'h3C, 1'b1, 4'd0,  8'h30, 1'b0, 0};
    vt[7]  = '{kNOP,  8'h12, 8'h34, 1'b1, 4'd0,  8'h00, 1'b0, 0};
    vt[8]  = '{kRSH,  8'h81, 8'h00, 1'b0, 4'd2,  8'h20, 1'b0, 2};
    vt[9]  = '{kLSH,  8'h81, 8'h00, 1'b0, 4'd15, 8'h00, 1'b1, 8};
    vt[10] = '{kSUB,  8'h03, 8'h05, 1'b0, 4'd0,  8'hFE, 1'b0, 0};
    vt[11] = '{kADD,  8'hFF, 8'h01, 1'b0, 4'd0,  8'h00, 1'b1, 0};
    vt[12] = '{kLFSR, 8'h01, 8'h00, 1'b0, 4'd15, 8'h00, 1'b0, 15};
    vt[13] = '{kRSH,  8'hC3, 8'h00, 1'b1, 4'd8,  8'hFF, 1'b1, 8};

    // Reset state
    #12;
    chk("rst_out", Out, 0);
    chk("rst_sc", SC_out, 0);
    chk("rst_zero", Zero, 1);
    chk("rst_pf", PF, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();

    foreach (vt[i]) begin
      exp_busy = (BARREL && (vt[i].op == kLSH || vt[i].op == kRSH)) ? 0 : vt[i].busy;
      Start = 1'b1; OP = vt[i].op; InputA = vt[i].a; InputB = vt[i].b;
      SC_in = vt[i].sc; Cnt = vt[i].cnt;
      tick();
      Start = 1'b0;
      busy_n = 0; guard = 0;
      while (!Done && guard < 40) begin
        if (Busy) busy_n++;
        tick();
        guard++;
      end
      chk($sformatf("v%0d_done_seen", i), Done, 1);
      chk($sformatf("v%0d_busy_cycles", i), busy_n, exp_busy);
      chk($sformatf("v%0d_busy_at_done", i), Busy, 0);
      chk($sformatf("v%0d_out", i), Out, vt[i].eo);
      chk($sformatf("v%0d_sc", i), SC_out, vt[i].es);
      chk($sformatf("v%0d_zero", i), Zero, (vt[i].eo == 8'h00));
      chk($sformatf("v%0d_pf", i), PF, ^vt[i].eo);
      tick();
      chk($sformatf("v%0d_done_pulse", i), Done, 0);
      chk($sformatf("v%0d_out_held", i), Out, vt[i].eo);
    end

    // Start while busy is ignored: one Done, LFSR result only
    Start = 1'b1; OP = kLFSR; InputA = 8'h01; InputB = 8'h00; SC_in = 1'b0; Cnt = 4'd5;
    tick();
    OP = kADD; InputA = 8'h10; InputB = 8'h10;
    tick();
    Start = 1'b0;
    dones = 0; last_out = '0;
    for (int c = 0; c < 12; c++) begin
      if (Done) begin dones++; last_out = Out; end
      tick();
    end
    chk("busy_ignore_dones", dones, 1);
    chk("busy_ignore_out", last_out, 8'h20);
    chk("busy_ignore_out_held", Out, 8'h20);

    // Reset mid-operation aborts with no Done
    Start = 1'b1; OP = kLFSR; InputA = 8'hFF; InputB = 8'h00; Cnt = 4'd5;
    tick();
    Start = 1'b0;
    chk("abort_busy_pre", Busy, 1);
    tick();
    #2 Reset_n = 1'b0;
    #1;
    chk("abort_busy", Busy, 0);
    chk("abort_out", Out, 0);
    chk("abort_zero", Zero, 1);
    @(negedge Clk);
    Reset_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (Done) dones++;
    end
    chk("abort_no_done", dones, 0);
    chk("abort_out_after", Out, 0);

    // Back-to-back issue while Done is high
    Start = 1'b1; OP = kADD; InputA = 8'h01; InputB = 8'h02; SC_in = 1'b0; Cnt = 4'd0;
    tick();
    chk("b2b_done1", Done, 1);
    chk("b2b_out1", Out, 8'h03);
    OP = kXOR; InputA = 8'h0F; InputB = 8'hFF;
    tick();
    Start = 1'b0;
    chk("b2b_done2", Done, 1);
    chk("b2b_out2", Out, 8'hF0);
    chk("b2b_pf2", PF, 0);
    tick();
    chk("b2b_done_low", Done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
